// File: rtl/infer_seq_param.sv
// Inference sequencer: loads one image into a pixel buffer, runs two layer engines in turn,
// then takes a sequential argmax over the logits and presents class/score on a result port.
module infer_seq_param #(
    parameter int N_PIX        = 64,
    parameter int PIX_W        = 2,
    parameter int PIX_PER_BEAT = 4,
    parameter int N_CLASS      = 10,
    parameter int LOGIT_W      = 6,
    parameter int CLS_W        = 4,
    parameter int TIMEOUT_CYC  = 8191
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          abort,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [PIX_PER_BEAT*PIX_W-1:0] in_data,
    output logic [N_PIX*PIX_W-1:0]        pix_flat,
    output logic                          l1_start,
    input  logic                          l1_done,
    output logic                          l2_start,
    input  logic                          l2_done,
    output logic [CLS_W-1:0]              logit_addr,
    input  logic [LOGIT_W-1:0]            logit_data,
    output logic                          busy,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [CLS_W-1:0]              res_class,
    output logic [LOGIT_W-1:0]            res_score,
    output logic                          res_err
);

    localparam int N_BEATS = N_PIX / PIX_PER_BEAT;
    localparam int BEAT_W  = PIX_PER_BEAT * PIX_W;
    localparam int BC_W    = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam int WD_W    = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_L1, S_L2, S_ARGMAX, S_RESULT} state_t;

    state_t                      state, state_nx;
    logic [BC_W-1:0]             beat_cnt;
    logic [WD_W-1:0]             wd_cnt;
    logic [BEAT_W-1:0]           beat_mem [N_BEATS];
    logic signed [LOGIT_W-1:0]   best_score;
    logic [CLS_W-1:0]            best_idx;
    logic signed [LOGIT_W-1:0]   cur_logit;
    logic                        take;
    logic accept, last_beat, l1_seen, l2_seen, wd_expire, am_last;

    // Both ports: a transfer happens on a rising edge where valid and ready are both high;
    // the source holds data stable while valid is high and ready is low.
    assign in_ready  = (state == S_IDLE) || (state == S_LOAD);
    assign busy      = !((state == S_IDLE) || (state == S_RESULT));
    assign res_valid = (state == S_RESULT);

    assign cur_logit = logit_data;
    assign take      = (logit_addr == '0) || (cur_logit > best_score);

    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        last_beat = 1'b0;
        l1_seen   = 1'b0;
        l2_seen   = 1'b0;
        wd_expire = 1'b0;
        am_last   = 1'b0;
        case (state)
            S_IDLE, S_LOAD: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (beat_cnt == BC_W'(N_BEATS - 1)) begin
                        last_beat = 1'b1;
                        state_nx  = S_L1;
                    end else begin
                        state_nx  = S_LOAD;
                    end
                end
            end
            S_L1: begin
                if (l1_done && !l1_start) begin
                    l1_seen  = 1'b1;
                    state_nx = S_L2;
                end else if (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
                    wd_expire = 1'b1;
                    state_nx  = S_RESULT;
                end
            end
            S_L2: begin
                if (l2_done && !l2_start) begin
                    l2_seen  = 1'b1;
                    state_nx = S_ARGMAX;
                end else if (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
                    wd_expire = 1'b1;
                    state_nx  = S_RESULT;
                end
            end
            S_ARGMAX: begin
                if (logit_addr == CLS_W'(N_CLASS - 1)) begin
                    am_last  = 1'b1;
                    state_nx = S_RESULT;
                end
            end
            S_RESULT: begin
                if (res_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        if (abort) state_nx = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Pixel storage is deliberately left out of reset; a partial frame is simply overwritten.
    always_ff @(posedge clk) begin
        if (accept && !abort) beat_mem[beat_cnt] <= in_data;
    end

    for (genvar k = 0; k < N_BEATS; k++) begin : g_flat
        assign pix_flat[k*BEAT_W +: BEAT_W] = beat_mem[k];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt   <= '0;
            wd_cnt     <= '0;
            l1_start   <= 1'b0;
            l2_start   <= 1'b0;
            logit_addr <= '0;
            best_score <= '0;
            best_idx   <= '0;
            res_class  <= '0;
            res_score  <= '0;
            res_err    <= 1'b0;
        end else if (abort) begin
            beat_cnt   <= '0;
            wd_cnt     <= '0;
            l1_start   <= 1'b0;
            l2_start   <= 1'b0;
            logit_addr <= '0;
            res_err    <= 1'b0;
        end else begin
            l1_start <= last_beat;
            l2_start <= l1_seen;
            if (last_beat)   beat_cnt <= '0;
            else if (accept) beat_cnt <= beat_cnt + BC_W'(1);
            if (last_beat || l1_seen)                wd_cnt <= '0;
            else if (state == S_L1 || state == S_L2) wd_cnt <= wd_cnt + WD_W'(1);
            if (l2_seen) begin
                logit_addr <= '0;
            end else if (state == S_ARGMAX) begin
                if (take) begin
                    best_score <= cur_logit;
                    best_idx   <= logit_addr;
                end
                logit_addr <= am_last ? '0 : logit_addr + CLS_W'(1);
            end
            // The last logit is folded in combinationally so RESULT follows immediately.
            if (am_last) begin
                res_class <= take ? logit_addr : best_idx;
                res_score <= take ? cur_logit : best_score;
                res_err   <= 1'b0;
            end else if (wd_expire) begin
                res_class <= '0;
                res_score <= '0;
                res_err   <= 1'b1;
            end else if (state == S_RESULT && res_ready) begin
                res_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_infer_seq_param.sv
// Bench for infer_seq_param: a default-shaped instance (short watchdog) and a small-parameter instance.
module tb_infer_seq_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic rst_n;

    // Instance A: N_PIX=64, PIX_W=2, 4 pixels/beat, 10 classes, watchdog 100
    logic         a_abort, a_in_valid, a_in_ready, a_l1_start, a_l1_done, a_l2_start, a_l2_done;
    logic         a_busy, a_res_valid, a_res_ready, a_res_err;
    logic [7:0]   a_in_data;
    logic [127:0] a_pix_flat;
    logic [3:0]   a_logit_addr, a_res_class;
    logic [5:0]   a_logit_data, a_res_score;

    infer_seq_param #(.N_PIX(64), .PIX_W(2), .PIX_PER_BEAT(4), .N_CLASS(10), .LOGIT_W(6),
                      .CLS_W(4), .TIMEOUT_CYC(100)) u_a (
        .clk(clk), .rst_n(rst_n), .abort(a_abort), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .pix_flat(a_pix_flat), .l1_start(a_l1_start), .l1_done(a_l1_done),
        .l2_start(a_l2_start), .l2_done(a_l2_done), .logit_addr(a_logit_addr),
        .logit_data(a_logit_data), .busy(a_busy), .res_valid(a_res_valid), .res_ready(a_res_ready),
        .res_class(a_res_class), .res_score(a_res_score), .res_err(a_res_err));

    // Instance B: N_PIX=16, PIX_W=4, 2 pixels/beat, 3 classes
    logic        b_abort, b_in_valid, b_in_ready, b_l1_start, b_l1_done, b_l2_start, b_l2_done;
    logic        b_busy, b_res_valid, b_res_ready, b_res_err;
    logic [7:0]  b_in_data;
    logic [63:0] b_pix_flat;
    logic [1:0]  b_logit_addr, b_res_class;
    logic [5:0]  b_logit_data, b_res_score;

    infer_seq_param #(.N_PIX(16), .PIX_W(4), .PIX_PER_BEAT(2), .N_CLASS(3), .LOGIT_W(6),
                      .CLS_W(2), .TIMEOUT_CYC(100)) u_b (
        .clk(clk), .rst_n(rst_n), .abort(b_abort), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .pix_flat(b_pix_flat), .l1_start(b_l1_start), .l1_done(b_l1_done),
        .l2_start(b_l2_start), .l2_done(b_l2_done), .logit_addr(b_logit_addr),
        .logit_data(b_logit_data), .busy(b_busy), .res_valid(b_res_valid), .res_ready(b_res_ready),
        .res_class(b_res_class), .res_score(b_res_score), .res_err(b_res_err));

    // Layer engine models: done pulses 5 (A) / 3 (B) cycles after the start pulse
    logic              a_l1_en = 1'b1, a_l2_en = 1'b1;
    int                a_c1 = 0, a_c2 = 0, b_c1 = 0, b_c2 = 0;
    logic signed [5:0] a_logits [16];
    logic signed [5:0] b_logits [4];
    always @(posedge clk) begin
        a_c1 <= a_l1_start ? 5 : (a_c1 > 0 ? a_c1 - 1 : 0);
        a_c2 <= a_l2_start ? 5 : (a_c2 > 0 ? a_c2 - 1 : 0);
        b_c1 <= b_l1_start ? 3 : (b_c1 > 0 ? b_c1 - 1 : 0);
        b_c2 <= b_l2_start ? 3 : (b_c2 > 0 ? b_c2 - 1 : 0);
    end
    assign a_l1_done    = a_l1_en && (a_c1 == 1);
    assign a_l2_done    = a_l2_en && (a_c2 == 1);
    assign b_l1_done    = (b_c1 == 1);
    assign b_l2_done    = (b_c2 == 1);
    assign a_logit_data = a_logits[a_logit_addr];
    assign b_logit_data = b_logits[b_logit_addr];

    int a_l1s_cyc = 0, a_l2d_cyc = 0, b_l2d_cyc = 0;
    always @(negedge clk) begin
        if (a_l1_start) a_l1s_cyc = cyc;
        if (a_l2_done)  a_l2d_cyc = cyc;
        if (b_l2_done)  b_l2d_cyc = cyc;
    end

    logic [1:0]  a_pix [64];
    logic [10:0] exp_q [$];

    // Reference: highest logit wins, earliest index on a tie
    function automatic logic [10:0] a_ref();
        int bi = 0;
        for (int i = 1; i < 10; i++) if (a_logits[i] > a_logits[bi]) bi = i;
        return {1'b0, 4'(bi), 6'(a_logits[bi])};
    endfunction

    function automatic logic [8:0] b_ref();
        int bi = 0;
        for (int i = 1; i < 3; i++) if (b_logits[i] > b_logits[bi]) bi = i;
        return {1'b0, 2'(bi), 6'(b_logits[bi])};
    endfunction

    function automatic logic [127:0] a_exp_flat();
        logic [127:0] f = '0;
        for (int p = 0; p < 64; p++) f[p*2 +: 2] = a_pix[p];
        return f;
    endfunction

    task automatic a_rand_frame();
        int mode = $urandom_range(3, 0);
        for (int p = 0; p < 64; p++) a_pix[p] = 2'($urandom_range(3, 0));
        for (int i = 0; i < 10; i++)
            a_logits[i] = (mode == 0) ? (($urandom_range(1, 0) == 1) ? 6'sd31 : -6'sd32)
                                      : 6'($urandom_range(63, 0));
    endtask

    task automatic a_send(input int nbeats, input int gap_max);
        int   g, guard;
        logic rdy;
        @(posedge clk); #1;
        for (int k = 0; k < nbeats; k++) begin
            g = $urandom_range(gap_max, 0);
            repeat (g) begin @(posedge clk); #1; end
            a_in_valid = 1'b1;
            for (int j = 0; j < 4; j++) a_in_data[j*2 +: 2] = a_pix[k*4 + j];
            guard = 0;
            do begin
                @(negedge clk); rdy = a_in_ready;
                @(posedge clk); #1; guard++;
            end while (!rdy && guard < 200);
            if (!rdy) check("in_ready_timeout", rdy, 1);
            a_in_valid = 1'b0;
            a_in_data  = 8'($urandom);
        end
        if (nbeats == 16) begin
            @(negedge clk);
            check("l1_start_latency", a_l1_start, 1);
            check("in_ready_in_l1", a_in_ready, 0);
            check("pix_flat", a_pix_flat, a_exp_flat());
        end
    endtask

    task automatic a_take(input int hold);
        int          guard = 0;
        logic [10:0] e;
        do begin @(negedge clk); guard++; end while (!a_res_valid && guard < 400);
        check("res_valid_timeout", a_res_valid, 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check("result", {a_res_err, a_res_class, a_res_score}, e);
        if (!e[10]) check("l2done_to_res", cyc - a_l2d_cyc, 11);
        else        check("wdog_window", (cyc - a_l1s_cyc >= 98) && (cyc - a_l1s_cyc <= 102), 1);
        check("busy_in_result", a_busy, 0);
        check("in_ready_in_result", a_in_ready, 0);
        repeat (hold) begin
            @(negedge clk);
            check("hold_stable", {a_res_valid, a_in_ready, a_res_err, a_res_class, a_res_score},
                  {1'b1, 1'b0, e});
        end
        a_res_ready = 1'b1;
        @(posedge clk); #1;
        a_res_ready = 1'b0;
        @(negedge clk);
        check("res_valid_after_take", a_res_valid, 0);
        check("idle_after_take", a_in_ready, 1);
    endtask

    task automatic b_frame();
        logic [3:0]  pix [16];
        logic [63:0] ef;
        logic [8:0]  e;
        logic        rdy;
        int          guard;
        for (int p = 0; p < 16; p++) begin
            pix[p] = 4'($urandom_range(15, 0));
            ef[p*4 +: 4] = pix[p];
        end
        for (int i = 0; i < 3; i++) b_logits[i] = 6'($urandom_range(63, 0));
        if ($urandom_range(1, 0) == 1) b_logits[2] = b_logits[1];
        e = b_ref();
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) begin
            b_in_valid = 1'b1;
            b_in_data  = {pix[2*k + 1], pix[2*k]};
            guard = 0;
            do begin
                @(negedge clk); rdy = b_in_ready;
                @(posedge clk); #1; guard++;
            end while (!rdy && guard < 200);
            if (!rdy) check("b_in_ready_timeout", rdy, 1);
            b_in_valid = 1'b0;
        end
        @(negedge clk);
        check("b_l1_start_latency", b_l1_start, 1);
        check("b_pix_flat", b_pix_flat, ef);
        guard = 0;
        do begin @(negedge clk); guard++; end while (!b_res_valid && guard < 400);
        check("b_res_valid_timeout", b_res_valid, 1);
        check("b_result", {b_res_err, b_res_class, b_res_score}, e);
        check("b_l2done_to_res", cyc - b_l2d_cyc, 4);
        b_res_ready = 1'b1;
        @(posedge clk); #1;
        b_res_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int   guard;
        logic seen;
        rst_n = 1'b0;
        a_abort = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_res_ready = 1'b0;
        b_abort = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_res_ready = 1'b0;
        for (int i = 0; i < 16; i++) a_logits[i] = '0;
        for (int i = 0; i < 4; i++)  b_logits[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", a_in_ready, 1);
        check("rst_busy", a_busy, 0);
        check("rst_res_valid", a_res_valid, 0);
        check("rst_outputs", {a_res_err, a_res_class, a_res_score}, 0);
        check("rst_starts", {a_l1_start, a_l2_start}, 0);
        check("rst_logit_addr", a_logit_addr, 0);
        check("b_rst", {b_in_ready, b_busy, b_res_valid}, 3'b100);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed frame: 0xE4 beats, logits with a tie at the maximum
        for (int p = 0; p < 64; p++) a_pix[p] = 2'(p % 4);
        a_logits[0] = -6'sd3; a_logits[1] = 6'sd1;   a_logits[2] = 6'sd7;  a_logits[3] = 6'sd7;
        a_logits[4] = 6'sd0;  a_logits[5] = -6'sd32; a_logits[6] = 6'sd2;  a_logits[7] = 6'sd31;
        a_logits[8] = 6'sd31; a_logits[9] = 6'sd5;
        exp_q.push_back({1'b0, 4'd7, 6'd31});
        a_send(16, 0);
        a_take(0);

        // All logits at the negative rail, then a single one just above it at the last index
        for (int i = 0; i < 10; i++) a_logits[i] = -6'sd32;
        exp_q.push_back({1'b0, 4'd0, 6'h20});
        a_send(16, 1);
        a_take(0);
        a_logits[9] = -6'sd31;
        exp_q.push_back({1'b0, 4'd9, 6'h21});
        a_send(16, 1);
        a_take(0);

        // Back-pressure on the result port, then a second frame
        a_rand_frame();
        exp_q.push_back(a_ref());
        a_send(16, 2);
        a_take(20);
        a_rand_frame();
        exp_q.push_back(a_ref());
        a_send(16, 0);
        a_take(0);

        // Layer 1 never finishes: watchdog result
        a_l1_en = 1'b0;
        a_rand_frame();
        exp_q.push_back({1'b1, 4'd0, 6'd0});
        a_send(16, 0);
        a_take(2);
        a_l1_en = 1'b1;

        // Abort after 8 beats, then a full new frame: exactly one result
        a_rand_frame();
        a_send(8, 1);
        a_abort = 1'b1;
        @(posedge clk); #1;
        a_abort = 1'b0;
        @(negedge clk);
        check("abort_load_idle", {a_in_ready, a_busy}, 2'b10);
        a_rand_frame();
        exp_q.push_back(a_ref());
        a_send(16, 1);
        a_take(0);
        seen = 1'b0;
        repeat (20) begin @(negedge clk); seen = seen | a_res_valid; end
        check("no_extra_result", seen, 0);

        // Abort during layer 2
        a_rand_frame();
        a_send(16, 0);
        guard = 0;
        do begin @(negedge clk); guard++; end while (!a_l2_start && guard < 100);
        check("l2_start_timeout", a_l2_start, 1);
        @(posedge clk); #1;
        a_abort = 1'b1;
        @(posedge clk); #1;
        a_abort = 1'b0;
        @(negedge clk);
        check("abort_l2", {a_res_valid, a_busy, a_in_ready}, 3'b001);

        // Abort while a watchdog error result is waiting
        a_l1_en = 1'b0;
        a_rand_frame();
        a_send(16, 0);
        guard = 0;
        do begin @(negedge clk); guard++; end while (!a_res_valid && guard < 400);
        check("wdog_res_timeout", a_res_valid, 1);
        a_abort = 1'b1;
        @(posedge clk); #1;
        a_abort = 1'b0;
        a_l1_en = 1'b1;
        @(negedge clk);
        check("abort_result", {a_res_valid, a_res_err, a_in_ready}, 3'b001);

        // Randomised frames with gaps and random result back-pressure
        for (int f = 0; f < 16; f++) begin
            a_rand_frame();
            exp_q.push_back(a_ref());
            a_send(16, $urandom_range(2, 0));
            a_take($urandom_range(4, 0));
        end
        check("exp_q_drained", exp_q.size(), 0);

        // Small-parameter instance: pixel ordering and 3-cycle argmax
        for (int f = 0; f < 4; f++) b_frame();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
